// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single data memory port: the pipeline (port 0) has fixed priority,
// the loader/debug master (port 1) is guaranteed a grant after MAX_WAIT denied cycles.
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             gnt0,
    output logic             stall0,
    output logic             rvalid0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] mem_rdaddress,
    output logic             mem_rden,
    output logic [WIDTH-1:0] mem_wraddress,
    output logic             mem_wren,
    input  logic [WIDTH-1:0] mem_q
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0]     waitCnt_q, waitCnt_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] port_q, port_d;
    logic              pri1;

    // Grants and memory drive; everything is forced quiet while reset is asserted.
    always_comb begin
        pri1          = (waitCnt_q >= CW'(MAX_WAIT));
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        stall0        = 1'b0;
        mem_data      = '0;
        mem_rdaddress = '0;
        mem_wraddress = '0;
        mem_rden      = 1'b0;
        mem_wren      = 1'b0;
        if (reset_n) begin
            gnt1   = req1 && (!req0 || pri1);
            gnt0   = req0 && !(req1 && pri1);
            stall0 = req0 && !gnt0;
        end
        if (gnt0) begin
            mem_rdaddress = addr0;
            mem_wraddress = addr0;
            mem_data      = wdata0;
            mem_rden      = !we0;
            mem_wren      = we0;
        end else if (gnt1) begin
            mem_rdaddress = addr1;
            mem_wraddress = addr1;
            mem_data      = wdata1;
            mem_rden      = !we1;
            mem_wren      = we1;
        end
    end

    // Starvation counter and read-return tracking pipe (only reads are pushed as valid).
    always_comb begin
        waitCnt_d = '0;
        if (req1 && !gnt1) begin
            waitCnt_d = (waitCnt_q < CW'(MAX_WAIT)) ? waitCnt_q + CW'(1) : waitCnt_q;
        end
        vld_d     = vld_q;
        port_d    = port_q;
        vld_d[0]  = mem_rden;
        port_d[0] = gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            port_d[i] = port_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            waitCnt_q <= '0;
            vld_q     <= '0;
            port_q    <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
            vld_q     <= vld_d;
            port_q    <= port_d;
        end
    end

    assign rvalid0 = vld_q[RD_LAT-1] && !port_q[RD_LAT-1];
    assign rvalid1 = vld_q[RD_LAT-1] &&  port_q[RD_LAT-1];
    assign rdata0  = mem_q;
    assign rdata1  = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; three instances share stimulus with RD_LAT = 1, 2 and 3.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [31:0] memQ;

    logic        gnt0W[3], stall0W[3], rvalid0W[3], gnt1W[3], rvalid1W[3];
    logic        memRdenW[3], memWrenW[3];
    logic [31:0] rdata0W[3], rdata1W[3], memDataW[3], memRdaddrW[3], memWraddrW[3];

    int errCount;
    int checkCount;

    always #5 clock = ~clock;

    for (genvar k = 0; k < 3; k++) begin : gInst
        dmem_arbiter #(
            .WIDTH(32),
            .RD_LAT(k + 1),
            .MAX_WAIT(4)
        ) uDut (
            .clock(clock),
            .reset_n(reset_n),
            .req0(req0),
            .we0(we0),
            .addr0(addr0),
            .wdata0(wdata0),
            .gnt0(gnt0W[k]),
            .stall0(stall0W[k]),
            .rvalid0(rvalid0W[k]),
            .rdata0(rdata0W[k]),
            .req1(req1),
            .we1(we1),
            .addr1(addr1),
            .wdata1(wdata1),
            .gnt1(gnt1W[k]),
            .rvalid1(rvalid1W[k]),
            .rdata1(rdata1W[k]),
            .mem_data(memDataW[k]),
            .mem_rdaddress(memRdaddrW[k]),
            .mem_rden(memRdenW[k]),
            .mem_wraddress(memWraddrW[k]),
            .mem_wren(memWrenW[k]),
            .mem_q(memQ)
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic flush();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) stepCycle();
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        reset_n    = 1'b0;
        memQ       = '0;
        applyStimulus(1, 0, 32'h11, 32'h22, 1, 1, 32'h33, 32'h44);

        // Reset with both ports requesting: everything stays silent.
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("rst gnt0[%0d]", k), 32'(gnt0W[k]), 0);
                checkOutput($sformatf("rst gnt1[%0d]", k), 32'(gnt1W[k]), 0);
                checkOutput($sformatf("rst stall0[%0d]", k), 32'(stall0W[k]), 0);
                checkOutput($sformatf("rst rden[%0d]", k), 32'(memRdenW[k]), 0);
                checkOutput($sformatf("rst wren[%0d]", k), 32'(memWrenW[k]), 0);
                checkOutput($sformatf("rst rvalid0[%0d]", k), 32'(rvalid0W[k]), 0);
                checkOutput($sformatf("rst rvalid1[%0d]", k), 32'(rvalid1W[k]), 0);
            end
            stepCycle();
        end

        // Starvation: port 0 read vs port 1 write, port 1 wins every fifth cycle.
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checkOutput($sformatf("starve gnt0 c%0d", c), 32'(gnt0W[0]), 32'(c % 5 != 4));
            checkOutput($sformatf("starve gnt1 c%0d", c), 32'(gnt1W[0]), 32'(c % 5 == 4));
            checkOutput($sformatf("starve stall0 c%0d", c), 32'(stall0W[0]), 32'(c % 5 == 4));
            checkOutput($sformatf("starve gnt1 lat3 c%0d", c), 32'(gnt1W[2]), 32'(c % 5 == 4));
            if (c % 5 == 4) begin
                checkOutput("starve wren", 32'(memWrenW[0]), 1);
                checkOutput("starve rden", 32'(memRdenW[0]), 0);
                checkOutput("starve wraddr", memWraddrW[0], 32'h33);
                checkOutput("starve data", memDataW[0], 32'h44);
            end else begin
                checkOutput("starve rden", 32'(memRdenW[0]), 1);
                checkOutput("starve wren", 32'(memWrenW[0]), 0);
                checkOutput("starve rdaddr", memRdaddrW[0], 32'h11);
                checkOutput("starve data", memDataW[0], 32'h22);
            end
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("idle rdaddr", memRdaddrW[0], 0);
        checkOutput("idle wraddr", memWraddrW[0], 0);
        checkOutput("idle data", memDataW[0], 0);
        checkOutput("idle stall0", 32'(stall0W[0]), 0);
        flush();

        // Single port-1 read; response latency observed on all three instances.
        applyStimulus(0, 0, 0, 0, 1, 0, 32'd5, 0);
        @(negedge clock);
        checkOutput("rd gnt1", 32'(gnt1W[0]), 1);
        checkOutput("rd gnt0", 32'(gnt0W[0]), 0);
        checkOutput("rd rdaddr", memRdaddrW[0], 32'd5);
        checkOutput("rd rden", 32'(memRdenW[0]), 1);
        checkOutput("rd wren", 32'(memWrenW[0]), 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        memQ = 32'h1234;
        @(negedge clock);
        checkOutput("rd c1 rvalid1 lat1", 32'(rvalid1W[0]), 1);
        checkOutput("rd c1 rvalid0 lat1", 32'(rvalid0W[0]), 0);
        checkOutput("rd c1 rdata1 lat1", rdata1W[0], 32'h1234);
        checkOutput("rd c1 rdata0 lat1", rdata0W[0], 32'h1234);
        checkOutput("rd c1 rvalid1 lat2", 32'(rvalid1W[1]), 0);
        stepCycle();
        @(negedge clock);
        checkOutput("rd c2 rvalid1 lat1", 32'(rvalid1W[0]), 0);
        checkOutput("rd c2 rvalid1 lat2", 32'(rvalid1W[1]), 1);
        checkOutput("rd c2 rvalid1 lat3", 32'(rvalid1W[2]), 0);
        stepCycle();
        @(negedge clock);
        checkOutput("rd c3 rvalid1 lat2", 32'(rvalid1W[1]), 0);
        checkOutput("rd c3 rvalid1 lat3", 32'(rvalid1W[2]), 1);
        checkOutput("rd c3 rvalid0 lat3", 32'(rvalid0W[2]), 0);
        flush();

        // Interleaved reads port0/port1/port0 checked at RD_LAT = 2 (and 1).
        memQ = '0;
        applyStimulus(1, 0, 32'd1, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("il c0 gnt0", 32'(gnt0W[1]), 1);
        checkOutput("il c0 rdaddr", memRdaddrW[1], 32'd1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 1, 0, 32'd2, 0);
        @(negedge clock);
        checkOutput("il c1 rdaddr", memRdaddrW[1], 32'd2);
        checkOutput("il c1 rvalid0 lat1", 32'(rvalid0W[0]), 1);
        checkOutput("il c1 rvalid0 lat2", 32'(rvalid0W[1]), 0);
        stepCycle();
        applyStimulus(1, 0, 32'd3, 0, 0, 0, 0, 0);
        memQ = 32'hA1;
        @(negedge clock);
        checkOutput("il c2 rvalid0", 32'(rvalid0W[1]), 1);
        checkOutput("il c2 rvalid1", 32'(rvalid1W[1]), 0);
        checkOutput("il c2 rdata0", rdata0W[1], 32'hA1);
        checkOutput("il c2 rvalid1 lat1", 32'(rvalid1W[0]), 1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        memQ = 32'hB2;
        @(negedge clock);
        checkOutput("il c3 rvalid1", 32'(rvalid1W[1]), 1);
        checkOutput("il c3 rvalid0", 32'(rvalid0W[1]), 0);
        checkOutput("il c3 rdata1", rdata1W[1], 32'hB2);
        stepCycle();
        memQ = 32'hC3;
        @(negedge clock);
        checkOutput("il c4 rvalid0", 32'(rvalid0W[1]), 1);
        checkOutput("il c4 rvalid1", 32'(rvalid1W[1]), 0);
        checkOutput("il c4 rdata0", rdata0W[1], 32'hC3);
        stepCycle();
        @(negedge clock);
        checkOutput("il c5 rvalid0", 32'(rvalid0W[1]), 0);
        checkOutput("il c5 rvalid1", 32'(rvalid1W[1]), 0);
        flush();

        // Port 0 write: completes in the grant cycle, never produces a response.
        applyStimulus(1, 1, 32'd7, 32'hDEAD, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("wr gnt0", 32'(gnt0W[0]), 1);
        checkOutput("wr wren", 32'(memWrenW[0]), 1);
        checkOutput("wr rden", 32'(memRdenW[0]), 0);
        checkOutput("wr wraddr", memWraddrW[0], 32'd7);
        checkOutput("wr data", memDataW[0], 32'hDEAD);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("wr c%0d rvalid0[%0d]", c, k), 32'(rvalid0W[k]), 0);
                checkOutput($sformatf("wr c%0d rvalid1[%0d]", c, k), 32'(rvalid1W[k]), 0);
            end
            stepCycle();
        end

        // Reset one cycle after a port-0 read: the in-flight read is dropped.
        applyStimulus(1, 0, 32'd9, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("mr c0 rden", 32'(memRdenW[2]), 1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            checkOutput($sformatf("mr c%0d rvalid0 lat2", c), 32'(rvalid0W[1]), 0);
            checkOutput($sformatf("mr c%0d rvalid0 lat3", c), 32'(rvalid0W[2]), 0);
            stepCycle();
            reset_n = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
